qam16_rx_demapper: RTL and testbench
====================================

# qam16_rx_demapper

Receive-side counterpart of the scrambled 16-QAM transmit chain. It takes hard I/Q symbol samples (signed 8-bit, the same format the transmit mapper produces) and slices them to Gray-coded nibbles. It descrambles them with the same 7-bit additive LFSR, packs two symbols per byte and delivers the bytes through a 4-entry output FIFO with ready/valid flow control. It sits directly behind the channel/sample interface and feeds the byte-level protocol logic.

## Interface
- LEVEL_A, 32: inner constellation amplitude A; levels are ±A and ±3A; legal range 1..42.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset; one clock; asynchronous and active-low.
- lfsr_seed  in  7  descrambler seed; sampled when lfsr_load=1.
- lfsr_load  in  1  loads the seed, clears the nibble pointer and clears the pipeline stage.
- I_in  in  8  signed in-phase sample.
- Q_in  in  8  signed quadrature sample.
- valid_in  in  1  sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- data_out  out  8  descrambled byte at the FIFO head.
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  consumer takes the byte.
- sym_count  out  16  accepted-symbol counter; wraps at 65535→0.

## Operation
- **Slicer**
  - Compare in 9-bit signed arithmetic against thresholds 0 and ±2A. Apply the rule to I for bits b3b2 and to Q for b1b0:
    - x ≥ 2A → 10
    - 0 ≤ x < 2A → 11
    - −2A ≤ x < 0 → 01
    - x < −2A → 00
  - Exact threshold values resolve as listed: 0 → 11, +2A → 10, −2A → 01.
- **Descrambler**
  - lfsr[6:0] steps once per bit, four steps unrolled per symbol.
  - f = lfsr[6]^lfsr[3]; next lfsr = {lfsr[5:0], f}; out_bit = raw_bit ^ f.
  - Bit order is b3 first.
  - Seed 0 gives f=0 permanently, i.e. pass-through.
- **Packing**
  - The first symbol after a load or reset forms byte[7:4]; the second forms byte[3:0].
  - A 1-bit half pointer toggles on each accepted symbol.
- **Accept and stage**
  - A sample is accepted when valid_in & in_ready.
  - The LFSR, half pointer and sym_count update on acceptance.
  - On the second half, the completed byte goes into a one-entry stage register and is written to the FIFO on the next edge.
- **FIFO**
  - Read pointer, write pointer and count, depth FIFO_DEPTH.
  - Pop when data_valid & data_ready.
  - Simultaneous push and pop on a full or non-empty FIFO is legal; the count is unchanged.
- **Flow control**
  - in_ready = !lfsr_load && (count + stage_full < FIFO_DEPTH).
  - Combined with the stage register, this makes overflow impossible; no data is ever dropped.
- **lfsr_load**
  - Takes priority over acceptance.
  - Discards a pending half byte and the stage register.
  - Leaves FIFO contents intact.
  - Does not count a symbol.
- **sym_count** counts accepted samples only.

## Timing
- **Reset (async assert, sync-safe deassert use)**
  - lfsr = 0, half = 0, stage empty, FIFO empty.
  - in_ready = 1, data_valid = 0, data_out = 0, sym_count = 0.
- **Latency**
  - Second symbol accepted at edge t → byte in stage after t → written to FIFO at edge t+1 → data_valid = 1 after t+1 when the FIFO was empty.
  - That is 2 cycles from sample to byte.
- **Throughput:** one symbol per cycle, i.e. one byte per 2 cycles.
- **data_out** is driven from the FIFO head combinationally from registers; it holds stable while data_valid & !data_ready.
- **Reset mid-operation** clears everything immediately, including queued bytes.

## Test plan
- **Seed 0 pass-through:** load seed 7'h00, then send (I,Q)=(96,−32) followed by (−96,32) → data_out = 8'h93, data_valid high 2 cycles after the 2nd sample, sym_count = 2.
- **Seed 0x55 descramble:** load seed 7'b1010101, then send (32,32) followed by (−32,−96). Keystream is 1111,0100 → data_out = 8'h00.
- **Threshold boundaries:** seed 0, samples (0,64) followed by (−64,−65) → nibbles 1110, 0100 → 8'hE4.
- **Backpressure:** data_ready held 0 and valid_in continuous → exactly FIFO_DEPTH bytes are accepted and in_ready falls. Then release data_ready → bytes emerge in order with none lost or duplicated.
- **lfsr_load mid-byte:** one symbol accepted, then lfsr_load pulsed with seed 0 → half byte discarded. The next two symbols form a fresh byte and the existing FIFO bytes are unchanged.
- **Async reset mid-stream:** reset_n asserted while the FIFO holds 3 bytes → data_valid = 0 and sym_count = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/qam16_rx_demapper_if.sv
// Sample-in / byte-out bus of the 16-QAM receive demapper.
// The slave side is the demapper; the master side is whoever feeds samples and consumes bytes.
interface qam16_rx_demapper_if;
    logic [6:0]        lfsr_seed;
    logic              lfsr_load;
    logic signed [7:0] I_in;
    logic signed [7:0] Q_in;
    logic              valid_in;
    logic              in_ready;
    logic [7:0]        data_out;
    logic              data_valid;
    logic              data_ready;
    logic [15:0]       sym_count;

    modport slave (
        input  lfsr_seed, lfsr_load, I_in, Q_in, valid_in, data_ready,
        output in_ready, data_out, data_valid, sym_count
    );

    modport master (
        output lfsr_seed, lfsr_load, I_in, Q_in, valid_in, data_ready,
        input  in_ready, data_out, data_valid, sym_count
    );
endinterface

// File: rtl/qam16_rx_demapper.sv
// 16-QAM hard slicer + additive LFSR descrambler + nibble packer feeding a small byte FIFO.
// Completed bytes pass through a one-entry stage register before entering the FIFO.
module qam16_rx_demapper #(
    parameter int LEVEL_A    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    qam16_rx_demapper_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic signed [8:0] THR  = 9'(2 * LEVEL_A);
    localparam logic signed [8:0] NTHR = -THR;

    logic [6:0]    lfsr_q, lfsr_d, lfsr_n;
    logic          half_q, half_d;
    logic [3:0]    nib_hi_q, nib_hi_d;
    logic [7:0]    stage_q, stage_d;
    logic          stage_full_q, stage_full_d;
    logic [15:0]   sym_count_q, sym_count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    raw, ks, nib;
    logic          accept, push, pop;

    function automatic logic [1:0] slice(input logic signed [7:0] x);
        logic signed [8:0] xs;
        xs = {x[7], x};
        if (xs >= THR)          return 2'b10;
        else if (xs >= 9'sd0)   return 2'b11;
        else if (xs >= NTHR)    return 2'b01;
        else                    return 2'b00;
    endfunction

    // Four LFSR steps per symbol; first keystream bit lands in ks[3] to pair with b3.
    always_comb begin
        raw    = {slice(bus.I_in), slice(bus.Q_in)};
        lfsr_n = lfsr_q;
        ks     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            ks     = {ks[2:0], lfsr_n[6] ^ lfsr_n[3]};
            lfsr_n = {lfsr_n[5:0], lfsr_n[6] ^ lfsr_n[3]};
        end
        nib = raw ^ ks;
    end

    assign bus.in_ready   = !bus.lfsr_load &&
                            ((count_q + CW'(stage_full_q)) < CW'(FIFO_DEPTH));
    assign bus.data_valid = (count_q != '0);
    assign bus.data_out   = mem_q[rd_ptr_q];
    assign bus.sym_count  = sym_count_q;

    assign accept = bus.valid_in && bus.in_ready;
    // in_ready reserves a slot for the staged byte, so the push never needs a space check.
    assign push   = stage_full_q && !bus.lfsr_load;
    assign pop    = bus.data_valid && bus.data_ready;

    always_comb begin
        lfsr_d       = lfsr_q;
        half_d       = half_q;
        nib_hi_d     = nib_hi_q;
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        sym_count_d  = sym_count_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);

        if (push) begin
            mem_d[wr_ptr_q] = stage_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            stage_full_d    = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (bus.lfsr_load) begin
            lfsr_d       = bus.lfsr_seed;
            half_d       = 1'b0;
            stage_full_d = 1'b0;
        end else if (accept) begin
            lfsr_d      = lfsr_n;
            half_d      = ~half_q;
            sym_count_d = sym_count_q + 16'd1;
            if (!half_q) begin
                nib_hi_d = nib;
            end else begin
                stage_d      = {nib_hi_q, nib};
                stage_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q       <= '0;
            half_q       <= 1'b0;
            nib_hi_q     <= '0;
            stage_q      <= '0;
            stage_full_q <= 1'b0;
            sym_count_q  <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            lfsr_q       <= lfsr_d;
            half_q       <= half_d;
            nib_hi_q     <= nib_hi_d;
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
            sym_count_q  <= sym_count_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_qam16_rx_demapper.sv
// Randomized and directed bench for qam16_rx_demapper against a transaction-level model.
module tb_qam16_rx_demapper;
    localparam int A     = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    qam16_rx_demapper_if bus ();

    qam16_rx_demapper #(.LEVEL_A(A), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cur_i, cur_q;

    // Model: LFSR as an integer, bytes as a queue, staged byte waits one edge.
    int m_lfsr, m_half, m_hi, m_stage, m_stage_v, m_sym;
    int q[$];

    int pick[8] = '{0, 64, -64, -65, 63, -1, 127, -128};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sl(input int x);
        if (x >= 2 * A)       return 2;
        else if (x >= 0)      return 3;
        else if (x >= -2 * A) return 1;
        else                  return 0;
    endfunction

    task automatic model_reset();
        m_lfsr = 0; m_half = 0; m_hi = 0; m_stage = 0; m_stage_v = 0; m_sym = 0;
        q.delete();
    endtask

    function automatic int exp_ready();
        return (!bus.lfsr_load && (q.size() + m_stage_v < DEPTH)) ? 1 : 0;
    endfunction

    task automatic model_symbol(input int iv, input int qv);
        int raw, ks, f, nib;
        raw = sl(iv) * 4 + sl(qv);
        ks = 0;
        for (int k = 0; k < 4; k++) begin
            f = ((m_lfsr >> 6) ^ (m_lfsr >> 3)) & 1;
            ks = ks * 2 + f;
            m_lfsr = ((m_lfsr << 1) | f) & 127;
        end
        nib = raw ^ ks;
        if (m_half == 0) begin
            m_hi = nib; m_half = 1;
        end else begin
            m_stage = m_hi * 16 + nib; m_stage_v = 1; m_half = 0;
        end
        m_sym = (m_sym + 1) % 65536;
    endtask

    task automatic cycle();
        int acc, pp;
        @(negedge clk);
        chk("in_ready", int'(bus.in_ready), exp_ready());
        chk("data_valid", int'(bus.data_valid), (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) chk("data_out", int'(bus.data_out), q[0]);
        chk("sym_count", int'(bus.sym_count), m_sym);
        acc = (bus.valid_in && exp_ready() != 0) ? 1 : 0;
        pp  = (q.size() > 0 && bus.data_ready) ? 1 : 0;
        @(posedge clk);
        if (pp != 0) void'(q.pop_front());
        if (bus.lfsr_load) begin
            m_lfsr = int'(bus.lfsr_seed); m_half = 0; m_stage_v = 0;
        end else begin
            if (m_stage_v != 0) begin
                q.push_back(m_stage); m_stage_v = 0;
            end
            if (acc != 0) model_symbol(cur_i, cur_q);
        end
        #1;
    endtask

    task automatic drive(input int iv, input int qv, input bit v, input bit rdy,
                         input bit ld, input int seed);
        cur_i = iv; cur_q = qv;
        bus.I_in = 8'(iv); bus.Q_in = 8'(qv);
        bus.valid_in = v; bus.data_ready = rdy;
        bus.lfsr_load = ld; bus.lfsr_seed = 7'(seed);
        cycle();
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1'b0, rdy, 1'b0, 0);
    endtask

    task automatic pair_test(input string name, input int seed, input int i0, input int q0,
                             input int i1, input int q1, input int exp_byte);
        drive(0, 0, 1'b0, 1'b0, 1'b1, seed);
        drive(i0, q0, 1'b1, 1'b0, 1'b0, 0);
        drive(i1, q1, 1'b1, 1'b0, 1'b0, 0);
        chk({name, "_not_yet"}, int'(bus.data_valid), 0);
        idle(1'b0, 1);
        chk({name, "_valid"}, int'(bus.data_valid), 1);
        chk({name, "_byte"}, int'(bus.data_out), exp_byte);
        idle(1'b1, 1);
    endtask

    initial begin
        bus.I_in = '0; bus.Q_in = '0; bus.valid_in = 1'b0; bus.data_ready = 1'b0;
        bus.lfsr_load = 1'b0; bus.lfsr_seed = '0;
        cur_i = 0; cur_q = 0;
        model_reset();
        #12;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_data_valid", int'(bus.data_valid), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_sym_count", int'(bus.sym_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        pair_test("seed0", 0, 96, -32, -96, 32, 'h93);
        chk("seed0_symcnt", int'(bus.sym_count), 2);
        pair_test("seed55", 'h55, 32, 32, -32, -96, 'h00);
        pair_test("thresh", 0, 0, 64, -64, -65, 'hE4);
        chk("empty_after_pairs", int'(bus.data_valid), 0);

        // Backpressure: continuous samples, no consumer.
        for (int k = 0; k < 14; k++)
            drive(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                  1'b1, 1'b0, 1'b0, 0);
        chk("bp_symcnt", int'(bus.sym_count), 6 + 2 * DEPTH);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        chk("bp_valid", int'(bus.data_valid), 1);
        idle(1'b1, DEPTH + 2);
        chk("bp_drained", int'(bus.data_valid), 0);

        // Load mid-byte: one old byte stays, the half byte is dropped.
        drive(96, -32, 1'b1, 1'b0, 1'b0, 0);
        drive(-96, 32, 1'b1, 1'b0, 1'b0, 0);
        drive(0, 0, 1'b1, 1'b0, 1'b0, 0);
        drive(0, 0, 1'b0, 1'b0, 1'b1, 0);
        drive(32, -32, 1'b1, 1'b0, 1'b0, 0);
        drive(-32, 96, 1'b1, 1'b0, 1'b0, 0);
        idle(1'b0, 2);
        chk("load_symcnt", int'(bus.sym_count), 6 + 2 * DEPTH + 5);
        idle(1'b1, 1);
        chk("load_byte", int'(bus.data_out), 'hD6);
        chk("load_valid", int'(bus.data_valid), 1);
        idle(1'b1, 2);

        // Random traffic with occasional reseeding.
        for (int k = 0; k < 3000; k++) begin
            int iv, qv;
            iv = ($urandom_range(3) == 0) ? pick[$urandom_range(7)]
                                          : int'($urandom_range(255)) - 128;
            qv = ($urandom_range(3) == 0) ? pick[$urandom_range(7)]
                                          : int'($urandom_range(255)) - 128;
            drive(iv, qv, ($urandom_range(3) != 0), ($urandom_range(2) != 0),
                  ($urandom_range(63) == 0), int'($urandom_range(127)));
        end
        idle(1'b1, DEPTH + 3);

        // Async reset with three bytes queued.
        drive(0, 0, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 6; k++) drive(96, 96, 1'b1, 1'b0, 1'b0, 0);
        idle(1'b0, 2);
        chk("pre_rst_valid", int'(bus.data_valid), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(bus.data_valid), 0);
        chk("async_rst_symcnt", int'(bus.sym_count), 0);
        chk("async_rst_ready", int'(bus.in_ready), 1);
        chk("async_rst_data", int'(bus.data_out), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        pair_test("post_rst", 0, 96, -32, -96, 32, 'h93);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
